// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI4-Stream sequence checker.
// State encoding, error-code bit positions and a saturating increment.
package axis_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      TRACK
   } state_t;

   localparam int ERR_W     = 4;
   localparam int ERR_DATA  = 0;
   localparam int ERR_EARLY = 1;
   localparam int ERR_MISS  = 2;
   localparam int ERR_STRB  = 3;

   // Counters up to 32 bits wide; holds at all-ones of width w.
   function automatic logic [31:0] sat_inc(
      input logic [31:0] v,
      input int          w
   );
      logic [31:0] top;
      top = (w >= 32) ? '1 : ((32'h1 << w) - 32'h1);
      return (v >= top) ? top : v + 32'h1;
   endfunction

endpackage

// File: rtl/axis_ready_shaper.sv
// Backpressure generator: rotating ready mask and registered tready.
// tready depends only on enable and the mask, never on tvalid.
module axis_ready_shaper #(
   parameter logic [7:0] READY_PATTERN = 8'hFF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   output logic tready
);

   logic [7:0] mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask   <= READY_PATTERN;
         tready <= 1'b0;
      end else begin
         mask   <= {mask[0], mask[7:1]};
         tready <= enable & mask[0];
      end
   end

endmodule

// File: rtl/axis_seq_checker.sv
// AXI4-Stream sink checking frame length, tlast placement, strobes
// and incrementing data; reports saturating frame/error counters.
module axis_seq_checker
   import axis_pkg::*;
#(
   parameter int         NUMBER_OF_INPUT_WORDS  = 5,
   parameter int         C_S00_AXIS_TDATA_WIDTH = 32,
   parameter logic [7:0] READY_PATTERN          = 8'hFF,
   parameter int         CNT_WIDTH              = 16
) (
   input  logic                                s00_axis_aclk,
   input  logic                                s00_axis_aresetn,
   input  logic                                s00_axis_tvalid,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
   input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
   input  logic                                s00_axis_tlast,
   output logic                                s00_axis_tready,
   input  logic                                enable,
   input  logic                                clear,
   output logic [CNT_WIDTH-1:0]                frame_count,
   output logic [CNT_WIDTH-1:0]                error_count,
   output logic [ERR_W-1:0]                    last_error,
   output logic                                err_pulse,
   output logic                                locked
);

   localparam int N  = NUMBER_OF_INPUT_WORDS;
   localparam int W  = C_S00_AXIS_TDATA_WIDTH;
   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   state_t           state;
   state_t           state_nxt;
   logic [IW-1:0]    index;
   logic [W-1:0]     expected;
   logic             frame_ok;
   logic             beat;
   logic             at_last;
   logic             ok_now;
   logic             good_frame;
   logic [ERR_W-1:0] code;

   axis_ready_shaper #(
      .READY_PATTERN(READY_PATTERN)
   ) u_shaper (
      .clk   (s00_axis_aclk),
      .rst_n (s00_axis_aresetn),
      .enable(enable),
      .tready(s00_axis_tready)
   );

   assign beat    = s00_axis_tvalid & s00_axis_tready;
   assign at_last = (index == LAST_IDX);
   assign locked  = (state == TRACK);

   always_comb begin
      code            = '0;
      code[ERR_DATA]  = (state == TRACK) &&
                        (s00_axis_tdata != expected);
      code[ERR_EARLY] = s00_axis_tlast && !at_last;
      code[ERR_MISS]  = at_last && !s00_axis_tlast;
      code[ERR_STRB]  = (s00_axis_tstrb != '1);
   end

   // The ok flag restarts at the first beat of every frame.
   assign ok_now     = ((index == '0) || frame_ok) && (code == '0);
   assign good_frame = beat && at_last && s00_axis_tlast && ok_now;

   always_comb begin
      state_nxt = state;
      if (!enable) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE:    state_nxt = SYNC;
            SYNC:    if (beat) state_nxt = TRACK;
            TRACK:   state_nxt = TRACK;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) state <= IDLE;
      else                   state <= state_nxt;
   end

   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         index       <= '0;
         expected    <= '0;
         frame_ok    <= 1'b0;
         frame_count <= '0;
         error_count <= '0;
         last_error  <= '0;
         err_pulse   <= 1'b0;
      end else begin
         err_pulse <= beat && (code != '0);
         if (beat) begin
            if (s00_axis_tlast || at_last) index <= '0;
            else                           index <= index + 1'b1;
            expected <= s00_axis_tdata + 1'b1;
            frame_ok <= ok_now;
         end
         if (!enable) index <= '0;
         // Clear wins over any increment from a beat in the same cycle.
         if (clear) begin
            frame_count <= '0;
            error_count <= '0;
            last_error  <= '0;
         end else if (beat) begin
            if (good_frame)
               frame_count <= CNT_WIDTH'(sat_inc(32'(frame_count), CNT_WIDTH));
            if (code != '0) begin
               error_count <= CNT_WIDTH'(sat_inc(32'(error_count), CNT_WIDTH));
               last_error  <= code;
            end
         end
      end
   end

endmodule

// File: tb/tb_axis_seq_checker.sv
// Directed bench for axis_seq_checker: three instances cover the
// default config, an 8'h55 ready pattern and 2-bit counters.
module tb_axis_seq_checker;

   logic        clk = 1'b0;
   logic        aresetn = 1'b0;
   logic        tvalid = 1'b0;
   logic [31:0] tdata = '0;
   logic [3:0]  tstrb = 4'hF;
   logic        tlast = 1'b0;
   logic        enable = 1'b0;
   logic        enable55 = 1'b0;
   logic        clear = 1'b0;

   logic        tready, ep, locked;
   logic [15:0] fc, ec;
   logic [3:0]  le;
   logic        tready2, ep2, locked2;
   logic [1:0]  fc2, ec2;
   logic [3:0]  le2;
   logic        tready55, ep55, locked55;
   logic [15:0] fc55, ec55;
   logic [3:0]  le55;

   int checks = 0;
   int failures = 0;
   int pulses = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (ep === 1'b1) pulses <= pulses + 1;

   axis_seq_checker dut (
      .s00_axis_aclk   (clk),
      .s00_axis_aresetn(aresetn),
      .s00_axis_tvalid (tvalid),
      .s00_axis_tdata  (tdata),
      .s00_axis_tstrb  (tstrb),
      .s00_axis_tlast  (tlast),
      .s00_axis_tready (tready),
      .enable          (enable),
      .clear           (clear),
      .frame_count     (fc),
      .error_count     (ec),
      .last_error      (le),
      .err_pulse       (ep),
      .locked          (locked)
   );

   axis_seq_checker #(.CNT_WIDTH(2)) dut2 (
      .s00_axis_aclk   (clk),
      .s00_axis_aresetn(aresetn),
      .s00_axis_tvalid (tvalid),
      .s00_axis_tdata  (tdata),
      .s00_axis_tstrb  (tstrb),
      .s00_axis_tlast  (tlast),
      .s00_axis_tready (tready2),
      .enable          (enable),
      .clear           (clear),
      .frame_count     (fc2),
      .error_count     (ec2),
      .last_error      (le2),
      .err_pulse       (ep2),
      .locked          (locked2)
   );

   axis_seq_checker #(.READY_PATTERN(8'h55)) dut55 (
      .s00_axis_aclk   (clk),
      .s00_axis_aresetn(aresetn),
      .s00_axis_tvalid (tvalid),
      .s00_axis_tdata  (tdata),
      .s00_axis_tstrb  (tstrb),
      .s00_axis_tlast  (tlast),
      .s00_axis_tready (tready55),
      .enable          (enable55),
      .clear           (clear),
      .frame_count     (fc55),
      .error_count     (ec55),
      .last_error      (le55),
      .err_pulse       (ep55),
      .locked          (locked55)
   );

   task automatic send(input logic [31:0] d, input logic l,
                       input logic [3:0] s, input logic c);
      int n;
      @(negedge clk);
      tvalid = 1'b1;
      tdata  = d;
      tlast  = l;
      tstrb  = s;
      clear  = c;
      n = 0;
      while (!tready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!tready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout data=%0h tready stuck low", d);
         tvalid = 1'b0;
      end else begin
         @(posedge clk);
      end
   endtask

   task automatic send_run(input logic [31:0] base, input int n,
                           input logic last_on_end);
      for (int i = 0; i < n; i++)
         send(base + 32'(i), last_on_end && (i == n - 1), 4'hF, 1'b0);
   endtask

   task automatic idle();
      @(negedge clk);
      tvalid = 1'b0;
      tlast  = 1'b0;
      tstrb  = 4'hF;
      clear  = 1'b0;
      @(negedge clk);
   endtask

   task automatic resync();
      @(negedge clk);
      enable = 1'b0;
      repeat (2) @(negedge clk);
      enable = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (tready !== 1'b0) begin
         failures++;
         $display("FAIL reset_tready got=%b exp=0", tready);
      end
      checks++;
      if (fc !== 16'd0 || ec !== 16'd0) begin
         failures++;
         $display("FAIL reset_counts fc=%0d ec=%0d exp=0", fc, ec);
      end
      checks++;
      if (le !== 4'd0 || ep !== 1'b0 || locked !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags le=%b ep=%b lk=%b exp=0",
                  le, ep, locked);
      end
      @(negedge clk);
      aresetn = 1'b1;
      enable  = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (locked !== 1'b0 || tready !== 1'b1) begin
         failures++;
         $display("FAIL sync_wait lk=%b rdy=%b exp=0,1", locked, tready);
      end
   endtask

   task automatic test_basic();
      int p0;
      p0 = pulses;
      send_run(32'd2, 5, 1'b1);
      send_run(32'd7, 5, 1'b1);
      idle();
      checks++;
      if (fc !== 16'd2 || ec !== 16'd0) begin
         failures++;
         $display("FAIL basic_counts fc=%0d ec=%0d exp=2,0", fc, ec);
      end
      checks++;
      if (locked !== 1'b1 || pulses != p0) begin
         failures++;
         $display("FAIL basic_lock lk=%b pulses=%0d exp=1,0",
                  locked, pulses - p0);
      end
   endtask

   task automatic test_data_err();
      int p0;
      resync();
      p0 = pulses;
      send(32'd2, 1'b0, 4'hF, 1'b0);
      send(32'd3, 1'b0, 4'hF, 1'b0);
      send(32'd5, 1'b0, 4'hF, 1'b0);
      send(32'd6, 1'b0, 4'hF, 1'b0);
      send(32'd7, 1'b1, 4'hF, 1'b0);
      idle();
      checks++;
      if (pulses - p0 != 1) begin
         failures++;
         $display("FAIL data_pulse got=%0d exp=1", pulses - p0);
      end
      checks++;
      if (le !== 4'b0001 || fc !== 16'd2 || ec !== 16'd1) begin
         failures++;
         $display("FAIL data_err le=%b fc=%0d ec=%0d exp=0001,2,1",
                  le, fc, ec);
      end
      send_run(32'd8, 5, 1'b1);
      idle();
      checks++;
      if (fc !== 16'd3) begin
         failures++;
         $display("FAIL data_recover fc=%0d exp=3", fc);
      end
   endtask

   task automatic test_early_last();
      resync();
      send_run(32'd2, 3, 1'b1);
      idle();
      checks++;
      if (le !== 4'b0010 || ec !== 16'd2 || fc !== 16'd3) begin
         failures++;
         $display("FAIL early le=%b ec=%0d fc=%0d exp=0010,2,3",
                  le, ec, fc);
      end
      send_run(32'd5, 5, 1'b1);
      idle();
      checks++;
      if (fc !== 16'd4 || ec !== 16'd2) begin
         failures++;
         $display("FAIL early_next fc=%0d ec=%0d exp=4,2", fc, ec);
      end
   endtask

   task automatic test_missing_last();
      send_run(32'd10, 5, 1'b0);
      idle();
      checks++;
      if (le !== 4'b0100 || ec !== 16'd3 || fc !== 16'd4) begin
         failures++;
         $display("FAIL miss le=%b ec=%0d fc=%0d exp=0100,3,4",
                  le, ec, fc);
      end
      send_run(32'd15, 5, 1'b1);
      idle();
      checks++;
      if (fc !== 16'd5) begin
         failures++;
         $display("FAIL miss_next fc=%0d exp=5", fc);
      end
      checks++;
      if (fc2 !== 2'd3 || ec2 !== 2'd3) begin
         failures++;
         $display("FAIL sat_small fc2=%0d ec2=%0d exp=3,3", fc2, ec2);
      end
   endtask

   task automatic test_wrap();
      resync();
      send_run(32'hFFFF_FFFE, 5, 1'b1);
      idle();
      checks++;
      if (fc !== 16'd6 || ec !== 16'd3) begin
         failures++;
         $display("FAIL wrap fc=%0d ec=%0d exp=6,3", fc, ec);
      end
   endtask

   task automatic test_clear();
      int p0;
      p0 = pulses;
      send(32'd3, 1'b0, 4'hE, 1'b1);
      send_run(32'd4, 4, 1'b1);
      idle();
      checks++;
      if (fc !== 16'd0 || ec !== 16'd0 || le !== 4'd0) begin
         failures++;
         $display("FAIL clear fc=%0d ec=%0d le=%b exp=0,0,0",
                  fc, ec, le);
      end
      checks++;
      if (pulses - p0 != 1) begin
         failures++;
         $display("FAIL clear_pulse got=%0d exp=1", pulses - p0);
      end
      send_run(32'd8, 5, 1'b1);
      idle();
      checks++;
      if (fc !== 16'd1 || ec !== 16'd0) begin
         failures++;
         $display("FAIL clear_next fc=%0d ec=%0d exp=1,0", fc, ec);
      end
   endtask

   task automatic test_ready_pattern();
      int   b;
      int   bad;
      logic prev;
      @(negedge clk);
      enable   = 1'b0;
      enable55 = 1'b1;
      repeat (3) @(negedge clk);
      b    = 0;
      bad  = 0;
      prev = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i > 0 && tready55 === prev) bad++;
         prev   = tready55;
         tvalid = 1'b1;
         tdata  = 32'(100 + b);
         tlast  = (b % 5 == 4);
         tstrb  = 4'hF;
         if (tready55) b++;
      end
      idle();
      checks++;
      if (b != 10 || bad != 0) begin
         failures++;
         $display("FAIL pattern55 beats=%0d nontoggle=%0d exp=10,0",
                  b, bad);
      end
      checks++;
      if (fc55 !== 16'd2 || ec55 !== 16'd0) begin
         failures++;
         $display("FAIL pattern55_counts fc=%0d ec=%0d exp=2,0",
                  fc55, ec55);
      end
      checks++;
      if (fc !== 16'd1) begin
         failures++;
         $display("FAIL disabled_idle fc=%0d exp=1", fc);
      end
      enable55 = 1'b0;
   endtask

   task automatic test_reset_midframe();
      @(negedge clk);
      enable = 1'b1;
      repeat (2) @(negedge clk);
      send_run(32'd2, 3, 1'b0);
      @(negedge clk);
      tvalid = 1'b0;
      #2 aresetn = 1'b0;
      #1;
      checks++;
      if (tready !== 1'b0 || locked !== 1'b0 || fc !== 16'd0) begin
         failures++;
         $display("FAIL async_rst rdy=%b lk=%b fc=%0d exp=0,0,0",
                  tready, locked, fc);
      end
      checks++;
      if (fc55 !== 16'd0 || le !== 4'd0) begin
         failures++;
         $display("FAIL async_rst2 fc55=%0d le=%b exp=0,0", fc55, le);
      end
      @(negedge clk);
      aresetn = 1'b1;
      repeat (3) @(negedge clk);
      send_run(32'd100, 5, 1'b1);
      idle();
      checks++;
      if (fc !== 16'd1 || ec !== 16'd0 || locked !== 1'b1) begin
         failures++;
         $display("FAIL rst_resync fc=%0d ec=%0d lk=%b exp=1,0,1",
                  fc, ec, locked);
      end
      send_run(32'd105, 5, 1'b1);
      send_run(32'd110, 5, 1'b1);
      send_run(32'd115, 5, 1'b1);
      idle();
      checks++;
      if (fc !== 16'd4 || fc2 !== 2'd3) begin
         failures++;
         $display("FAIL sat_frames fc=%0d fc2=%0d exp=4,3", fc, fc2);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_data_err();
      test_early_last();
      test_missing_last();
      test_wrap();
      test_clear();
      test_ready_pattern();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
